// File: rtl/mul_pkg.sv
// Shared types for the repeated-addition multiply scheduler: default width,
// controller states and the requester id.
package mul_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ACC,
    S_DONE
  } state_t;

  typedef logic req_id_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the requests;
// the last-served pointer moves only on the update strobe.
module rr_arb2
  import mul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       upd,
  input  req_id_t    upd_id,
  output logic [1:0] gnt
);

  // Holds the id served last; reset to 1 so requester 0 wins the first tie.
  req_id_t r_last;

  always_ff @(posedge clk) begin
    if (rst)      r_last <= 1'b1;
    else if (upd) r_last <= upd_id;
  end

  assign gnt[0] = req0 & (~req1 | r_last);
  assign gnt[1] = req1 & ~gnt[0];

endmodule

// File: rtl/mul_sched.sv
// Arbitrates two multiply requesters and sequences an external
// repeated-addition datapath (A register, B down-counter, P accumulator).
//
// state  | meaning
// IDLE   | waiting; arbitrate and latch winner's operands
// LOAD_A | drive multiplicand onto bus, load A
// LOAD_B | drive multiplier onto bus, load B counter, clear P
// ACC    | add A into P and decrement B until B reaches zero
// DONE   | pulse done to owner, advance round-robin pointer
module mul_sched
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             lda,
  output logic             ldb,
  output logic             ldp,
  output logic             clrp,
  output logic             decb,
  output logic [WIDTH-1:0] data_bus,
  input  logic             eqz,
  input  logic [WIDTH-1:0] p_in
);

  state_t           r_state;
  req_id_t          r_own;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_bus;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_lda;
  logic             r_ldb;
  logic             r_clrp;
  logic             r_acc;

  logic [1:0]       w_arb_gnt;
  logic             w_upd;

  assign w_upd = (r_state == S_DONE);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .upd    (w_upd),
    .upd_id (r_own),
    .gnt    (w_arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_own    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_bus    <= '0;
      r_result <= '0;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_lda    <= 1'b0;
      r_ldb    <= 1'b0;
      r_clrp   <= 1'b0;
      r_acc    <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_arb_gnt != 2'b00) begin
            r_own   <= w_arb_gnt[1];
            r_a     <= w_arb_gnt[1] ? a1 : a0;
            r_b     <= w_arb_gnt[1] ? b1 : b0;
            r_bus   <= w_arb_gnt[1] ? a1 : a0;
            r_gnt   <= w_arb_gnt;
            r_lda   <= 1'b1;
            r_state <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          r_lda   <= 1'b0;
          r_ldb   <= 1'b1;
          r_clrp  <= 1'b1;
          r_bus   <= r_b;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_ldb   <= 1'b0;
          r_clrp  <= 1'b0;
          r_bus   <= '0;
          r_acc   <= 1'b1;
          r_state <= S_ACC;
        end
        S_ACC: begin
          // P is final on the eqz cycle, so capture it here and present it with done.
          if (eqz) begin
            r_acc    <= 1'b0;
            r_result <= p_in;
            r_done   <= id_onehot(r_own);
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accumulate strobes follow eqz in the same cycle, so they are gated rather than registered.
  assign ldp      = r_acc & ~eqz;
  assign decb     = r_acc & ~eqz;
  assign lda      = r_lda;
  assign ldb      = r_ldb;
  assign clrp     = r_clrp;
  assign data_bus = r_bus;
  assign gnt0     = r_gnt[0];
  assign gnt1     = r_gnt[1];
  assign done0    = r_done[0];
  assign done1    = r_done[1];
  assign result   = r_result;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: a behavioural repeated-addition datapath, directed
// requests feeding a scoreboard queue, and a monitor checking each done pulse.
module tb_mul_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, done0, done1, busy;
  logic         lda, ldb, ldp, clrp, decb, eqz;
  logic [W-1:0] result, data_bus, p_in;

  logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ldp_cnt = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    int           ldps;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  mul_sched #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .a0       (a0),
    .b0       (b0),
    .a1       (a1),
    .b1       (b1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .result   (result),
    .busy     (busy),
    .lda      (lda),
    .ldb      (ldb),
    .ldp      (ldp),
    .clrp     (clrp),
    .decb     (decb),
    .data_bus (data_bus),
    .eqz      (eqz),
    .p_in     (p_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // External datapath model
  always @(posedge clk) begin
    if (lda) dp_a <= data_bus;
    if (ldb) dp_b <= data_bus;
    else if (decb) dp_b <= dp_b - 1'b1;
    if (clrp) dp_p <= '0;
    else if (ldp) dp_p <= dp_p + dp_a;
  end
  assign eqz  = (dp_b == '0);
  assign p_in = dp_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) ldp_cnt = 0;
    else if (ldp) ldp_cnt++;
    checks++;
    if ((gnt0 && gnt1) || (done0 && done1) || (lda && ldb)) begin
      errors++;
      $display("FAIL exclusivity: gnt=%b%b done=%b%b lda/ldb=%b%b", gnt1, gnt0, done1, done0, lda, ldb);
    end
    if (!lda && !ldb) chk("bus_idle_zero", 32'(data_bus), 32'h0);
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=%b%b with empty scoreboard", done1, done0);
      end else begin
        e = sb.pop_front();
        chk("done_owner", {31'b0, done1}, {31'b0, e.id});
        chk("done_gnt", {30'b0, gnt1, gnt0}, e.id ? 32'h2 : 32'h1);
        chk("result", 32'(result), 32'(e.res));
        chk("ldp_cycles", 32'(ldp_cnt), 32'(e.ldps));
        if (e.cyc >= 0) chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
      ldp_cnt = 0;
    end
  end

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input bit lat);
    exp_t e;
    e.id   = id;
    e.res  = a * b;
    e.ldps = int'(b);
    e.cyc  = lat ? cyc + int'(b) + 4 : -1;
    sb.push_back(e);
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
  endtask

  task automatic wait_drop(input logic id);
    int n = 0;
    while (!(id ? done1 : done0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL timeout: no done for requester %0d", id);
    end
    @(posedge clk); #1;
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", {30'b0, gnt1, gnt0}, 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_ctrl", {27'b0, lda, ldb, ldp, clrp, decb}, 0);
    @(posedge clk); #1;

    // 17 x 5, done at c0+9
    issue(0, 16'd17, 16'd5, 1);
    wait_drop(0);
    chk("result_hold", 32'(result), 32'd85);

    // b = 0 -> single ACC cycle, result 0
    issue(0, 16'd9, 16'd0, 1);
    wait_drop(0);

    // truncation
    issue(1, 16'h0100, 16'h0100, 1);
    wait_drop(1);

    // simultaneous after reset: req0 then req1, then alternation
    do_reset();
    issue(0, 16'd3, 16'd4, 0);
    issue(1, 16'd6, 16'd7, 0);
    wait_drop(0);
    wait_drop(1);
    issue(0, 16'd2, 16'd3, 0);
    issue(1, 16'd5, 16'd5, 0);
    wait_drop(0);
    wait_drop(1);
    // req0 held after its done while req1 waits: req1 must win next
    issue(0, 16'd11, 16'd2, 0);
    issue(1, 16'd4, 16'd3, 0);
    @(negedge clk);
    while (!done0) @(negedge clk);
    a0 = 16'd10; b0 = 16'd10;
    begin exp_t e; e.id = 1'b0; e.res = 16'd100; e.ldps = 10; e.cyc = -1; sb.push_back(e); end
    wait_drop(1);
    wait_drop(0);

    // operands changed after grant
    issue(0, 16'd7, 16'd3, 1);
    @(posedge clk); #1;
    a0 = 16'd100; b0 = 16'd50;
    wait_drop(0);

    // reset during ACC aborts without done
    issue(0, 16'd5, 16'd10, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("in_acc_ldp", 32'(ldp), 1);
    void'(sb.pop_back());
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_gnt", {30'b0, gnt1, gnt0}, 0);
    chk("abort_done", {30'b0, done1, done0}, 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_ctrl", {27'b0, lda, ldb, ldp, clrp, decb}, 0);
    chk("abort_bus", 32'(data_bus), 0);
    repeat (3) @(posedge clk);
    #1;
    issue(0, 16'd4, 16'd6, 1);
    wait_drop(0);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
